// File: rtl/dyser_io_queues_pkg.sv
// dyser_io_queues_pkg
//   Shared configuration for the DySER send/recv port queues: default
//   widths and sizes, plus the pointer-width helper used by the top level
//   and by the per-port FIFO.
package dyser_io_queues_pkg;

  localparam int DATA_WIDTH   = 64;
  localparam int NPORTS_DEF   = 8;
  localparam int DEPTH_DEF    = 4;
  localparam int LANES_DEF    = 2;

  // FIFO pointer width: index bits plus one wrap bit, so that a full FIFO
  // (wptr - rptr == depth) is distinguishable from an empty one.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dyser_ioq_fifo.sv
// dyser_ioq_fifo
//   Circular FIFO that accepts up to NPUSH writes and up to NPOP reads per
//   cycle. The caller guarantees push_cnt <= free and pop_cnt <= count.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         synchronous clear; wins over same-cycle pushes and pops
//   push_cnt      number of entries written this cycle (slots 0..push_cnt-1)
//   push_data     NPUSH slots of DATA_W bits, slot k at [k*DATA_W +: DATA_W]
//   pop_cnt       number of entries removed from the head this cycle
//   peek_data     the NPOP oldest entries; slots beyond count read as 0
//   count         current occupancy (0..DEPTH)
module dyser_ioq_fifo
  import dyser_io_queues_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NPUSH  = LANES_DEF,
  parameter int NPOP   = 1,
  localparam int PW_D  = ptr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [PW_D-1:0]         push_cnt,
  input  logic [NPUSH*DATA_W-1:0] push_data,
  input  logic [PW_D-1:0]         pop_cnt,
  output logic [NPOP*DATA_W-1:0]  peek_data,
  output logic [PW_D-1:0]         count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW_D-1:0]   wptr;
  logic [PW_D-1:0]   rptr;

  assign count = wptr - rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + push_cnt;
      rptr <= rptr + pop_cnt;
    end
  end

  // Storage is not reset: entries are only ever observed through the
  // count-gated peek below, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int k = 0; k < NPUSH; k++) begin
        if (PW_D'(k) < push_cnt)
          mem[wptr[AW-1:0] + AW'(k)] <= push_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    peek_data = '0;
    for (int k = 0; k < NPOP; k++) begin
      if (PW_D'(k) < count)
        peek_data[k*DATA_W +: DATA_W] = mem[rptr[AW-1:0] + AW'(k)];
    end
  end

endmodule

// File: rtl/dyser_io_queues.sv
// dyser_io_queues
//   Send/recv port-queue front end between the core's dyser_send/dyser_recv
//   lanes and the DySER fabric ports. One FIFO per input port (core->fabric)
//   and one per output port (fabric->core). Lane groups are accepted
//   all-or-nothing; lanes naming the same port are ordered by lane index.
// Optional build macro:
//   DYSER_IOQ_OCC_EN  adds registered per-port occupancy output occ
//                     (input FIFOs in the low half, output FIFOs high).
// Ports:
//   clk, rst, flush                 clock, async reset, sync clear
//   send_data/send_port/send_en     core send lanes; send_stall rejects group
//   recv_port/recv_en               core recv lanes; recv_stall rejects group
//   recv_data                       popped (or would-be) data per lane
//   fin_data/fin_valid/fin_ready    input FIFO heads toward the fabric
//   fout_data/fout_valid/fout_ready fabric results into the output FIFOs
// Handshake: a fabric transfer happens on a rising edge where valid and
//   ready are both high; valid never depends on ready, ready never depends
//   on valid, and the data is held stable by the producer while valid.
module dyser_io_queues
  import dyser_io_queues_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int NPORTS = NPORTS_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LANES  = LANES_DEF,
  localparam int PW    = $clog2(NPORTS),
  localparam int PW_D  = ptr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [LANES*DATA_W-1:0]  send_data,
  input  logic [LANES*PW-1:0]      send_port,
  input  logic [LANES-1:0]         send_en,
  output logic                     send_stall,
  input  logic [LANES*PW-1:0]      recv_port,
  input  logic [LANES-1:0]         recv_en,
  output logic [LANES*DATA_W-1:0]  recv_data,
  output logic                     recv_stall,
  output logic [NPORTS*DATA_W-1:0] fin_data,
  output logic [NPORTS-1:0]        fin_valid,
  input  logic [NPORTS-1:0]        fin_ready,
  input  logic [NPORTS*DATA_W-1:0] fout_data,
  input  logic [NPORTS-1:0]        fout_valid,
  output logic [NPORTS-1:0]        fout_ready
`ifdef DYSER_IOQ_OCC_EN
  ,
  output logic [NPORTS*2*PW_D-1:0] occ
`endif
);

  // Wide enough for per-port lane counts and for free/count comparisons.
  localparam int CW = $clog2(LANES + DEPTH + 1) + 1;

  logic [PW-1:0]           s_port   [LANES];
  logic [PW-1:0]           r_port   [LANES];
  logic [CW-1:0]           s_rank   [LANES];
  logic [CW-1:0]           r_rank   [LANES];
  logic [CW-1:0]           need     [NPORTS];
  logic [CW-1:0]           req      [NPORTS];
  logic [PW_D-1:0]         in_count [NPORTS];
  logic [PW_D-1:0]         out_count[NPORTS];
  logic [PW_D-1:0]         in_push_cnt [NPORTS];
  logic [PW_D-1:0]         out_pop_cnt [NPORTS];
  logic [LANES*DATA_W-1:0] in_push_data[NPORTS];
  logic [LANES*DATA_W-1:0] out_peek    [NPORTS];
  logic [DATA_W-1:0]       in_peek     [NPORTS];

  // Lane decode, per-port demand and stall reduction. The rank of a lane is
  // the number of lower enabled lanes naming the same port: it selects the
  // push slot on send and the FIFO entry on recv.
  always_comb begin
    send_stall = 1'b0;
    recv_stall = 1'b0;
    recv_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      s_port[i] = send_port[i*PW +: PW];
      r_port[i] = recv_port[i*PW +: PW];
    end
    for (int i = 0; i < LANES; i++) begin
      s_rank[i] = '0;
      r_rank[i] = '0;
      for (int j = 0; j < i; j++) begin
        if (send_en[j] && s_port[j] == s_port[i]) s_rank[i] = s_rank[i] + 1'b1;
        if (recv_en[j] && r_port[j] == r_port[i]) r_rank[i] = r_rank[i] + 1'b1;
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      need[p] = '0;
      req[p]  = '0;
      for (int i = 0; i < LANES; i++) begin
        if (send_en[i] && s_port[i] == PW'(p)) need[p] = need[p] + 1'b1;
        if (recv_en[i] && r_port[i] == PW'(p)) req[p]  = req[p] + 1'b1;
      end
      // Free space and occupancy are taken before this cycle's fabric ops.
      if (need[p] > CW'(DEPTH) - CW'(in_count[p])) send_stall = 1'b1;
      if (req[p] > CW'(out_count[p]))              recv_stall = 1'b1;
    end
    for (int p = 0; p < NPORTS; p++) begin
      in_push_data[p] = '0;
      for (int k = 0; k < LANES; k++) begin
        for (int i = 0; i < LANES; i++) begin
          if (send_en[i] && s_port[i] == PW'(p) && s_rank[i] == CW'(k))
            in_push_data[p][k*DATA_W +: DATA_W] = send_data[i*DATA_W +: DATA_W];
        end
      end
      // need <= free <= DEPTH whenever the group is accepted, so it fits.
      in_push_cnt[p] = send_stall ? '0 : need[p][PW_D-1:0];
      out_pop_cnt[p] = recv_stall ? '0 : req[p][PW_D-1:0];
    end
    // Would-be values are shown even when stalled; the FIFO peek already
    // returns 0 for entries that do not exist.
    for (int i = 0; i < LANES; i++) begin
      if (recv_en[i]) begin
        for (int k = 0; k < LANES; k++) begin
          if (r_rank[i] == CW'(k))
            recv_data[i*DATA_W +: DATA_W] = out_peek[r_port[i]][k*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic fin_pop;
    logic fout_push;

    assign fin_valid[p]                   = (in_count[p] != '0);
    assign fin_data[p*DATA_W +: DATA_W]   = in_peek[p];
    assign fout_ready[p]                  = (out_count[p] < PW_D'(DEPTH));
    assign fin_pop                        = fin_valid[p] && fin_ready[p];
    assign fout_push                      = fout_valid[p] && fout_ready[p];

    dyser_ioq_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .NPUSH  (LANES),
      .NPOP   (1)
    ) u_in_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push_cnt  (in_push_cnt[p]),
      .push_data (in_push_data[p]),
      .pop_cnt   (PW_D'(fin_pop)),
      .peek_data (in_peek[p]),
      .count     (in_count[p])
    );

    dyser_ioq_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .NPUSH  (1),
      .NPOP   (LANES)
    ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push_cnt  (PW_D'(fout_push)),
      .push_data (fout_data[p*DATA_W +: DATA_W]),
      .pop_cnt   (out_pop_cnt[p]),
      .peek_data (out_peek[p]),
      .count     (out_count[p])
    );
  end

`ifdef DYSER_IOQ_OCC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        occ[p*PW_D +: PW_D]            <= in_count[p];
        occ[(NPORTS+p)*PW_D +: PW_D]   <= out_count[p];
      end
    end
  end
`endif

endmodule

// File: tb/tb_dyser_io_queues.sv
// tb_dyser_io_queues
//   Directed bench for dyser_io_queues with default parameters
//   (DATA_W=64, NPORTS=8, DEPTH=4, LANES=2).
module tb_dyser_io_queues;

  localparam int DW = 64;
  localparam int NP = 8;
  localparam int DEPTH = 4;
  localparam int LN = 2;
  localparam int PW = 3;
  localparam int PW_D = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [LN*DW-1:0]  send_data = '0;
  logic [LN*PW-1:0]  send_port = '0;
  logic [LN-1:0]     send_en = '0;
  logic              send_stall;
  logic [LN*PW-1:0]  recv_port = '0;
  logic [LN-1:0]     recv_en = '0;
  logic [LN*DW-1:0]  recv_data;
  logic              recv_stall;
  logic [NP*DW-1:0]  fin_data;
  logic [NP-1:0]     fin_valid;
  logic [NP-1:0]     fin_ready = '0;
  logic [NP*DW-1:0]  fout_data = '0;
  logic [NP-1:0]     fout_valid = '0;
  logic [NP-1:0]     fout_ready;
`ifdef DYSER_IOQ_OCC_EN
  logic [NP*2*PW_D-1:0] occ;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dyser_io_queues dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .send_data  (send_data),
    .send_port  (send_port),
    .send_en    (send_en),
    .send_stall (send_stall),
    .recv_port  (recv_port),
    .recv_en    (recv_en),
    .recv_data  (recv_data),
    .recv_stall (recv_stall),
    .fin_data   (fin_data),
    .fin_valid  (fin_valid),
    .fin_ready  (fin_ready),
    .fout_data  (fout_data),
    .fout_valid (fout_valid),
    .fout_ready (fout_ready)
`ifdef DYSER_IOQ_OCC_EN
    ,
    .occ        (occ)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    send_en    = '0;
    send_data  = '0;
    send_port  = '0;
    recv_en    = '0;
    recv_port  = '0;
    fout_valid = '0;
    fout_data  = '0;
  endtask

  task automatic drive_send(input int lane, input int port, input logic [DW-1:0] d);
    send_en[lane]               = 1'b1;
    send_port[lane*PW +: PW]    = PW'(port);
    send_data[lane*DW +: DW]    = d;
  endtask

  task automatic drive_recv(input int lane, input int port);
    recv_en[lane]               = 1'b1;
    recv_port[lane*PW +: PW]    = PW'(port);
  endtask

  task automatic drive_fout(input int port, input logic [DW-1:0] d);
    fout_valid[port]            = 1'b1;
    fout_data[port*DW +: DW]    = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_lanes();
    step(); step();
    vec_cnt++; if (send_stall !== 1'b0) begin err_cnt++; $display("FAIL reset_send_stall got %0b exp 0", send_stall); end
    vec_cnt++; if (recv_stall !== 1'b0) begin err_cnt++; $display("FAIL reset_recv_stall got %0b exp 0", recv_stall); end
    vec_cnt++; if (fin_valid !== 8'h00) begin err_cnt++; $display("FAIL reset_fin_valid got %h exp 00", fin_valid); end
    vec_cnt++; if (fout_ready !== 8'hff) begin err_cnt++; $display("FAIL reset_fout_ready got %h exp ff", fout_ready); end
    vec_cnt++; if (recv_data !== '0) begin err_cnt++; $display("FAIL reset_recv_data got %h exp 0", recv_data); end
    rst = 1'b0;
    step();
    vec_cnt++; if (fin_valid !== 8'h00 || fout_ready !== 8'hff) begin err_cnt++; $display("FAIL idle_after_reset fin_valid %h fout_ready %h exp 00/ff", fin_valid, fout_ready); end
  endtask

  task automatic test_send_basic();
    fin_ready = '0;
    drive_send(0, 4, 64'h0);
    drive_send(1, 2, 64'h1);
    #1;
    vec_cnt++; if (send_stall !== 1'b0) begin err_cnt++; $display("FAIL basic_send_stall got %0b exp 0", send_stall); end
    step();
    clear_lanes();
    #1;
    vec_cnt++; if (fin_valid !== 8'b0001_0100) begin err_cnt++; $display("FAIL basic_fin_valid got %b exp 00010100", fin_valid); end
    vec_cnt++; if (fin_data[4*DW +: DW] !== 64'h0) begin err_cnt++; $display("FAIL basic_fin_data4 got %h exp 0", fin_data[4*DW +: DW]); end
    vec_cnt++; if (fin_data[2*DW +: DW] !== 64'h1) begin err_cnt++; $display("FAIL basic_fin_data2 got %h exp 1", fin_data[2*DW +: DW]); end
    fin_ready = 8'hff;
    step();
    fin_ready = '0;
    #1;
    vec_cnt++; if (fin_valid !== 8'h00) begin err_cnt++; $display("FAIL basic_drain got %b exp 0", fin_valid); end
  endtask

  task automatic test_fill_stall();
    fin_ready = '0;
    // DEPTH/2+1 cycles of two lanes into port 3: the last one must stall.
    for (int c = 0; c <= DEPTH/2; c++) begin
      clear_lanes();
      drive_send(0, 3, 64'(2*c));
      drive_send(1, 3, 64'(2*c+1));
      #1;
      vec_cnt++;
      if (send_stall !== ((c == DEPTH/2) ? 1'b1 : 1'b0)) begin
        err_cnt++; $display("FAIL fill_stall_c%0d got %0b exp %0b", c, send_stall, (c == DEPTH/2));
      end
      step();
    end
    // Whole group rejected even though port 6 has room.
    clear_lanes();
    drive_send(0, 3, 64'h77);
    drive_send(1, 6, 64'h66);
    #1;
    vec_cnt++; if (send_stall !== 1'b1) begin err_cnt++; $display("FAIL group_stall got %0b exp 1", send_stall); end
    step();
    vec_cnt++; if (fin_valid !== 8'b0000_1000) begin err_cnt++; $display("FAIL no_partial_push got %b exp 00001000", fin_valid); end
    // Full FIFO popped by the fabric this cycle still refuses a send.
    clear_lanes();
    fin_ready = 8'h08;
    drive_send(0, 3, 64'h99);
    #1;
    vec_cnt++; if (send_stall !== 1'b1) begin err_cnt++; $display("FAIL no_passthrough_credit got %0b exp 1", send_stall); end
    vec_cnt++; if (fin_data[3*DW +: DW] !== 64'h0) begin err_cnt++; $display("FAIL drain_head0 got %h exp 0", fin_data[3*DW +: DW]); end
    step();
    clear_lanes();
    for (int k = 1; k < DEPTH; k++) begin
      #1;
      vec_cnt++;
      if (fin_valid[3] !== 1'b1 || fin_data[3*DW +: DW] !== 64'(k)) begin
        err_cnt++; $display("FAIL drain_head%0d got %0b/%h exp 1/%h", k, fin_valid[3], fin_data[3*DW +: DW], 64'(k));
      end
      step();
    end
    fin_ready = '0;
    vec_cnt++; if (fin_valid !== 8'h00) begin err_cnt++; $display("FAIL drain_empty got %b exp 0", fin_valid); end
  endtask

  task automatic test_recv();
    drive_fout(5, 64'h10); step();
    drive_fout(5, 64'h11); step();
    clear_lanes();
    drive_recv(0, 5);
    drive_recv(1, 5);
    #1;
    vec_cnt++; if (recv_stall !== 1'b0) begin err_cnt++; $display("FAIL recv2_stall got %0b exp 0", recv_stall); end
    vec_cnt++; if (recv_data !== {64'h11, 64'h10}) begin err_cnt++; $display("FAIL recv2_data got %h exp %h", recv_data, {64'h11, 64'h10}); end
    step();
    clear_lanes();
    drive_fout(5, 64'h12); step();
    clear_lanes();
    drive_recv(0, 5);
    drive_recv(1, 5);
    #1;
    vec_cnt++; if (recv_stall !== 1'b1) begin err_cnt++; $display("FAIL recv_short_stall got %0b exp 1", recv_stall); end
    vec_cnt++; if (recv_data !== {64'h0, 64'h12}) begin err_cnt++; $display("FAIL recv_short_data got %h exp %h", recv_data, {64'h0, 64'h12}); end
    step();
    // Entry survived the stalled request; lane 0 disabled shows 0.
    clear_lanes();
    drive_recv(1, 5);
    #1;
    vec_cnt++; if (recv_stall !== 1'b0 || recv_data !== {64'h12, 64'h0}) begin err_cnt++; $display("FAIL recv_after_stall got %0b/%h exp 0/%h", recv_stall, recv_data, {64'h12, 64'h0}); end
    step();
    // A same-cycle fabric push does not count toward this cycle's recv.
    clear_lanes();
    drive_recv(0, 5);
    drive_fout(5, 64'h13);
    #1;
    vec_cnt++; if (recv_stall !== 1'b1 || recv_data !== '0) begin err_cnt++; $display("FAIL recv_no_bypass got %0b/%h exp 1/0", recv_stall, recv_data); end
    step();
    clear_lanes();
    drive_recv(0, 5);
    #1;
    vec_cnt++; if (recv_stall !== 1'b0 || recv_data[DW-1:0] !== 64'h13) begin err_cnt++; $display("FAIL recv_next_cycle got %0b/%h exp 0/13", recv_stall, recv_data[DW-1:0]); end
    step();
    clear_lanes();
  endtask

  task automatic test_full_out();
    for (int k = 0; k < DEPTH; k++) begin
      clear_lanes();
      drive_fout(1, 64'(32 + k));
      #1;
      vec_cnt++; if (fout_ready[1] !== 1'b1) begin err_cnt++; $display("FAIL fill_out_ready%0d got %0b exp 1", k, fout_ready[1]); end
      step();
    end
    clear_lanes();
    drive_fout(1, 64'h24);
    drive_recv(0, 1);
    #1;
    vec_cnt++; if (fout_ready !== 8'hfd) begin err_cnt++; $display("FAIL full_out_ready got %h exp fd", fout_ready); end
    vec_cnt++; if (recv_stall !== 1'b0 || recv_data[DW-1:0] !== 64'h20) begin err_cnt++; $display("FAIL full_pop got %0b/%h exp 0/20", recv_stall, recv_data[DW-1:0]); end
    step();
    clear_lanes();
    #1;
    vec_cnt++; if (fout_ready[1] !== 1'b1) begin err_cnt++; $display("FAIL after_pop_ready got %0b exp 1", fout_ready[1]); end
    drive_recv(0, 1);
    drive_recv(1, 1);
    #1;
    vec_cnt++; if (recv_stall !== 1'b0 || recv_data !== {64'h22, 64'h21}) begin err_cnt++; $display("FAIL full_order got %0b/%h exp 0/%h", recv_stall, recv_data, {64'h22, 64'h21}); end
    step();
    clear_lanes();
    drive_recv(0, 1);
    #1;
    vec_cnt++; if (recv_stall !== 1'b0 || recv_data[DW-1:0] !== 64'h23) begin err_cnt++; $display("FAIL full_last got %0b/%h exp 0/23", recv_stall, recv_data[DW-1:0]); end
    step();
    // The push offered while full was not taken.
    #1;
    vec_cnt++; if (recv_stall !== 1'b1 || recv_data !== '0) begin err_cnt++; $display("FAIL full_dropped got %0b/%h exp 1/0", recv_stall, recv_data); end
    clear_lanes();
    step();
  endtask

  task automatic test_reset_mid();
    clear_lanes();
    drive_send(0, 0, 64'hA0);
    drive_send(1, 0, 64'hA1);
    step();
    clear_lanes();
    drive_fout(7, 64'hB0);
    step();
    clear_lanes();
    #1;
    vec_cnt++; if (fin_valid !== 8'h01 || fout_ready !== 8'hff) begin err_cnt++; $display("FAIL pre_reset got %h/%h exp 01/ff", fin_valid, fout_ready); end
    rst = 1'b1;
    #1;
    vec_cnt++; if (fin_valid !== 8'h00 || fin_data !== '0) begin err_cnt++; $display("FAIL async_reset_fin got %h exp 00", fin_valid); end
    drive_recv(0, 7);
    #1;
    vec_cnt++; if (recv_stall !== 1'b1 || recv_data !== '0) begin err_cnt++; $display("FAIL async_reset_recv got %0b/%h exp 1/0", recv_stall, recv_data); end
    step();
    rst = 1'b0;
    clear_lanes();
    step();
    drive_send(0, 0, 64'hC0);
    step();
    clear_lanes();
    #1;
    vec_cnt++; if (fin_valid !== 8'h01 || fin_data[DW-1:0] !== 64'hC0) begin err_cnt++; $display("FAIL post_reset_fresh got %h/%h exp 01/c0", fin_valid, fin_data[DW-1:0]); end
    fin_ready = 8'h01;
    step();
    fin_ready = '0;
  endtask

  task automatic test_flush();
    clear_lanes();
    drive_send(0, 2, 64'hD0);
    step();
    clear_lanes();
    flush = 1'b1;
    drive_send(0, 2, 64'hD1);
    drive_fout(4, 64'hE0);
    step();
    flush = 1'b0;
    clear_lanes();
    drive_recv(0, 4);
    #1;
    vec_cnt++; if (fin_valid !== 8'h00 || fout_ready !== 8'hff) begin err_cnt++; $display("FAIL flush_state got %h/%h exp 00/ff", fin_valid, fout_ready); end
    vec_cnt++; if (recv_stall !== 1'b1 || recv_data !== '0) begin err_cnt++; $display("FAIL flush_recv got %0b/%h exp 1/0", recv_stall, recv_data); end
    step();
    clear_lanes();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_send_basic();
    test_fill_stall();
    test_recv();
    test_full_out();
    test_reset_mid();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dyser_io_queues.md
# dyser_io_queues

Parametrised send/recv port-queue front end between the core's dyser_send/dyser_recv lanes and the DySER fabric's input and output ports. It generalises the fixed two-lane, 8-port interface to LANES lanes, NPORTS ports per direction, DEPTH-deep per-port FIFOs and DATA_W-bit data. It provides all-or-nothing lane acceptance, stall generation and in-order delivery per port. It sits directly under the dyser top, in front of the switch/FU grid.

## Interface
- DATA_W, 64: data width per lane and port.
- NPORTS, 8: input ports and output ports (power of 2); PW = log2(NPORTS).
- DEPTH, 4: entries per port FIFO (power of 2, ≥2).
- LANES, 2: send lanes and recv lanes per cycle.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all FIFOs; wins over same-cycle pushes and pops.
- send_data  in  LANES*DATA_W  lane i data at [i*DATA_W +: DATA_W].
- send_port  in  LANES*PW  target input port per lane.
- send_en  in  LANES  lane i valid.
- send_stall  out  1  whole send group rejected this cycle.
- recv_port  in  LANES*PW  source output port per lane.
- recv_en  in  LANES  lane i request.
- recv_data  out  LANES*DATA_W  popped data per lane.
- recv_stall  out  1  whole recv group not served this cycle.
- fin_data  out  NPORTS*DATA_W  head of each input FIFO to the fabric.
- fin_valid  out  NPORTS  input FIFO non-empty.
- fin_ready  in  NPORTS  fabric consumes the head.
- fout_data  in  NPORTS*DATA_W  fabric result per output port.
- fout_valid  in  NPORTS  fabric result present.
- fout_ready  out  NPORTS  output FIFO not full.

## Operation
- One FIFO per input port and one per output port, each DEPTH entries, with pointers PW_D = log2(DEPTH)+1 bits wide (extra wrap bit distinguishes full from empty).
- Send group:
  - need[p] = number of enabled lanes whose port is p.
  - send_stall = OR over p of (need[p] > free[p]).
  - Free space is counted before this cycle's fabric pops. No same-cycle pass-through credit.
  - No stall: every enabled lane is pushed. Lanes targeting the same port are pushed in ascending lane order.
  - Stall: nothing is pushed, so there is no partial acceptance.
- Recv group:
  - recv_stall = OR over p of (req[p] > count[p]), with count taken before this cycle's fabric pushes.
  - No stall: lane i receives entry k of its port, where k = number of lower enabled lanes naming the same port. Entries are popped at the clock edge.
  - Stall: nothing is popped. recv_data still shows the would-be values, and lanes without a valid entry show 0.
  - Disabled lanes show recv_data = 0.
- Fabric side:
  - Input FIFO p pops when fin_valid[p] && fin_ready[p].
  - Output FIFO p pushes when fout_valid[p] && fout_ready[p].
  - A push and a pop on the same FIFO in the same cycle both take effect; count is unchanged.
- Full/empty:
  - A full input FIFO stalls any send to that port.
  - An empty output FIFO stalls any recv from that port.
  - Pointer wrap at DEPTH is seamless.

## Timing
- send_stall, recv_stall, recv_data, fin_*, fout_ready are combinational from inputs and current state. There are no registered outputs.
- Send-to-fabric latency: data accepted at edge N appears on fin_data at edge N.
- Fabric-to-recv latency: fout accepted at edge N is readable by recv in cycle N+1.
- Reset (async, any time, including mid-group):
  - All FIFOs empty.
  - fin_valid = 0, fout_ready = all-1.
  - send_stall = 0 and recv_stall = 0 when no lane is enabled.
  - recv_data = 0.
- Entries in flight at reset are discarded.
- Flush: same as reset but synchronous; takes effect at the next edge.

## Configuration
- DYSER_IOQ_OCC_EN defined: adds output occ, NPORTS*2*PW_D bits, giving registered per-port occupancy.
  - Input FIFOs occupy the low half, output FIFOs the high half.
  - occ updates one cycle after the FIFO changes; reset value 0.
- DYSER_IOQ_OCC_EN undefined: the port is absent and there are no extra flops.

## Structure
- Widths and derived constants (PW, PW_D, lane-slice helpers) go in the shared dyser config include alongside DATA_WIDTH.
- One sub-module, dyser_ioq_fifo:
  - Multi-push/multi-pop circular FIFO (up to LANES pushes or LANES pops plus one fabric op per cycle).
  - Instantiated 2*NPORTS times.
- Lane-to-port demux and the stall reduction live in the top module.

## Test plan
- Reset then idle: all outputs at reset values; fout_ready = all-1; send_stall = recv_stall = 0.
- Send lanes (4, 0x0) and (2, 0x1); fabric holds fin_ready = 0 → fin_valid[4] = fin_valid[2] = 1, fin_data[4] = 0x0, no stall.
- Both lanes to port 3 for DEPTH/2+1 cycles with fin_ready = 0 → after DEPTH entries send_stall = 1 and nothing is pushed. Raise fin_ready[3] → entries drain in order 0..DEPTH-1.
- Fabric pushes 0x10 then 0x11 on output port 5; recv both lanes on port 5 → recv_data = {0x11, 0x10}, no stall. The same request with one entry present → recv_stall = 1, nothing popped.
- Simultaneous fabric push and recv pop on a full output FIFO → fout_ready = 0 that cycle; count drops by one; order preserved.
- Assert rst mid-stream with 3 entries queued → all FIFOs are empty immediately and stale data is never returned.
